// File: rtl/spi_frame_slave_pkg.sv
// Shared constants, FSM encoding and edge-selection helper for the SPI frame slave.
// Command/address codes and default field widths live here so every file agrees on them.
package spi_frame_slave_pkg;

    localparam int DEF_CMD_BITS     = 2;
    localparam int DEF_ADDR_BITS    = 4;
    localparam int DEF_PAYLOAD_BITS = 8;
    localparam int SYNC_STAGES      = 2;

    localparam logic [DEF_CMD_BITS-1:0]  CMD_NOP   = 2'b00;
    localparam logic [DEF_CMD_BITS-1:0]  CMD_READ  = 2'b01;
    localparam logic [DEF_CMD_BITS-1:0]  CMD_WRITE = 2'b10;
    localparam logic [DEF_ADDR_BITS-1:0] ADDR_NONE = 4'h0;
    localparam logic                     CS_ASSERT = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_PAYLOAD,
        S_DONE
    } state_t;

    // Data is sampled on the rising sclk edge when CPOL and CPHA agree.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_frame_slave_sync.sv
// spi_sync_edge: brings sclk/cs/mosi into the sysclk domain through equal-depth
// synchronisers and produces one-cycle sample/shift strobes from the sclk edges.
module spi_sync_edge
    import spi_frame_slave_pkg::*;
#(
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic sclk_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic cs_o,
    output logic mosi_o,
    output logic sample_o,
    output logic shift_o
);

    localparam logic SCLK_IDLE   = (CPOL != 0);
    localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    // cs resets to "asserted" so a reset taken mid-frame cannot look like a release.
    localparam logic [2:0] RESET_LEVELS = {SCLK_IDLE, CS_ASSERT, 1'b0};

    // bit 2 = sclk, bit 1 = cs, bit 0 = mosi
    logic [2:0] sync_q [SYNC_STAGES];
    logic       sclk_prev_q;
    logic       sclk_s;
    logic       rise;
    logic       fall;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_LEVELS;
            end
            sclk_prev_q <= SCLK_IDLE;
        end else begin
            sync_q[0] <= {sclk_i, cs_i, mosi_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_prev_q <= sync_q[SYNC_STAGES-1][2];
        end
    end

    assign sclk_s   = sync_q[SYNC_STAGES-1][2];
    assign cs_o     = sync_q[SYNC_STAGES-1][1];
    assign mosi_o   = sync_q[SYNC_STAGES-1][0];
    assign rise     = sclk_s & ~sclk_prev_q;
    assign fall     = ~sclk_s & sclk_prev_q;
    assign sample_o = SAMPLE_RISE ? rise : fall;
    assign shift_o  = SAMPLE_RISE ? fall : rise;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave that decodes cmd/addr/payload frames (MSB first) and, for read commands,
// returns a payload fetched from the host one cycle after o_tx_req.
module spi_frame_slave
    import spi_frame_slave_pkg::*;
#(
    parameter int CMD_BITS     = DEF_CMD_BITS,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int CPOL         = 0,
    parameter int CPHA         = 0
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    cs,
    input  logic                    mosi,
    output logic                    miso,
    output logic [CMD_BITS-1:0]     o_cmd,
    output logic [ADDR_BITS-1:0]    o_addr,
    output logic [PAYLOAD_BITS-1:0] o_payload,
    output logic                    o_rx_dv,
    output logic                    o_tx_req,
    input  logic [PAYLOAD_BITS-1:0] i_tx_data,
    output logic                    o_frame_err
);

    localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    logic cs_s;
    logic mosi_s;
    logic sample_edge;
    logic shift_edge;
    logic cs_active;

    spi_sync_edge #(
        .CPOL (CPOL),
        .CPHA (CPHA)
    ) u_sync (
        .clk_i    (sysclk),
        .srst_i   (rst),
        .sclk_i   (sclk),
        .cs_i     (cs),
        .mosi_i   (mosi),
        .cs_o     (cs_s),
        .mosi_o   (mosi_s),
        .sample_o (sample_edge),
        .shift_o  (shift_edge)
    );

    assign cs_active = (cs_s == CS_ASSERT);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-2:0]   rx_q, rx_d;
    logic [FRAME_BITS-1:0]   rx_shift;
    logic [PAYLOAD_BITS-1:0] tx_q, tx_d;
    logic                    is_read_q, is_read_d;
    logic                    shift_pend_q, shift_pend_d;
    logic                    load_pend_q, load_pend_d;
    logic                    armed_q, armed_d;
    logic [CMD_BITS-1:0]     cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
    logic                    rx_dv_q, rx_dv_d;
    logic                    tx_req_q, tx_req_d;
    logic                    frame_err_q, frame_err_d;
    logic [CNT_W-1:0]        field_last;

    assign rx_shift = {rx_q, mosi_s};

    always_comb begin
        field_last = '0;
        case (state_q)
            S_CMD:     field_last = CNT_W'(CMD_BITS - 1);
            S_ADDR:    field_last = CNT_W'(ADDR_BITS - 1);
            S_PAYLOAD: field_last = CNT_W'(PAYLOAD_BITS - 1);
            default:   field_last = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        is_read_d    = is_read_q;
        shift_pend_d = shift_pend_q;
        armed_d      = armed_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        payload_d    = payload_q;
        load_pend_d  = tx_req_q;
        rx_dv_d      = 1'b0;
        tx_req_d     = 1'b0;
        frame_err_d  = 1'b0;

        // A frame may only start once cs has been seen released (e.g. after reset).
        if (!cs_active) begin
            armed_d = 1'b1;
        end
        if (load_pend_q) begin
            tx_d = i_tx_data;
        end

        case (state_q)
            S_IDLE: begin
                if (cs_active && armed_q) begin
                    state_d      = S_CMD;
                    cnt_d        = '0;
                    rx_d         = '0;
                    tx_d         = '0;
                    is_read_d    = 1'b0;
                    shift_pend_d = 1'b0;
                end
            end
            S_CMD, S_ADDR, S_PAYLOAD: begin
                if (!cs_active) begin
                    state_d     = S_IDLE;
                    frame_err_d = !((state_q == S_CMD) && (cnt_q == '0));
                end else if (sample_edge) begin
                    rx_d         = rx_shift[FRAME_BITS-2:0];
                    cnt_d        = cnt_q + 1'b1;
                    shift_pend_d = (state_q == S_PAYLOAD);
                    if (cnt_q == field_last) begin
                        cnt_d = '0;
                        case (state_q)
                            S_CMD: state_d = S_ADDR;
                            S_ADDR: begin
                                state_d   = S_PAYLOAD;
                                is_read_d = (rx_shift[ADDR_BITS +: CMD_BITS] == CMD_BITS'(CMD_READ));
                                tx_req_d  = is_read_d;
                            end
                            default: begin
                                state_d   = S_DONE;
                                cmd_d     = rx_shift[FRAME_BITS-1 -: CMD_BITS];
                                addr_d    = rx_shift[PAYLOAD_BITS +: ADDR_BITS];
                                payload_d = rx_shift[PAYLOAD_BITS-1:0];
                                rx_dv_d   = 1'b1;
                            end
                        endcase
                    end
                end else if (shift_edge && shift_pend_q) begin
                    // Advance miso only after the master has sampled the current payload bit.
                    tx_d         = tx_q << 1;
                    shift_pend_d = 1'b0;
                end
            end
            S_DONE: begin
                if (!cs_active) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            is_read_q    <= 1'b0;
            shift_pend_q <= 1'b0;
            load_pend_q  <= 1'b0;
            armed_q      <= 1'b0;
            cmd_q        <= CMD_BITS'(CMD_NOP);
            addr_q       <= ADDR_BITS'(ADDR_NONE);
            payload_q    <= '0;
            rx_dv_q      <= 1'b0;
            tx_req_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            is_read_q    <= is_read_d;
            shift_pend_q <= shift_pend_d;
            load_pend_q  <= load_pend_d;
            armed_q      <= armed_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            payload_q    <= payload_d;
            rx_dv_q      <= rx_dv_d;
            tx_req_q     <= tx_req_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign miso        = is_read_q && ((state_q == S_PAYLOAD) || (state_q == S_DONE)) && tx_q[PAYLOAD_BITS-1];
    assign o_cmd       = cmd_q;
    assign o_addr      = addr_q;
    assign o_payload   = payload_q;
    assign o_rx_dv     = rx_dv_q;
    assign o_tx_req    = tx_req_q;
    assign o_frame_err = frame_err_q;

endmodule
